// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports with write bypass, one write port,
// a per-register pending scoreboard for hazard detection, and a valid/ready register dump engine.

module regfile_param_entry #(
    parameter int DATA_W = 16,
    parameter bit ZERO   = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pend_set,
    output logic [DATA_W-1:0] value,
    output logic              pend
);
    // A hardwired-zero entry is simply held in reset forever.
    always_ff @(posedge clk) begin
        if (rst || ZERO) begin
            value <= '0;
            pend  <= 1'b0;
        end else begin
            if (wr_en)
                value <= wr_data;
            // A new producer issuing in the same cycle as the old one retires keeps the reg pending.
            if (pend_set)
                pend <= 1'b1;
            else if (wr_en)
                pend <= 1'b0;
        end
    end
endmodule

module regfile_param #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    output logic              pend_a,
    output logic              pend_b,
    input  logic              dump_start,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [DATA_W-1:0] dump_data
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    typedef enum logic [1:0] {IDLE, FETCH, SEND} dump_state_t;

    wr_req_t                        wr_req;
    logic [DEPTH-1:0][DATA_W-1:0]   mem;
    logic [DEPTH-1:0]               pend;

    assign wr_req = '{en: we, addr: wr_addr, data: wr_data};

    // ------------------------------------------------------------------
    // Storage and scoreboard: one entry per register
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        regfile_param_entry #(
            .DATA_W (DATA_W),
            .ZERO   (ZERO_R0 && (i == 0))
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_req.en && (wr_req.addr == ADDR_W'(i))),
            .wr_data  (wr_req.data),
            .pend_set (pend_set && (pend_addr == ADDR_W'(i))),
            .value    (mem[i]),
            .pend     (pend[i])
        );
    end

    // ------------------------------------------------------------------
    // Read ports: same-cycle write is forwarded, and so is its pending clear
    // ------------------------------------------------------------------
    logic hit_a, hit_b;

    always_comb begin
        hit_a = wr_req.en && (wr_req.addr == rd_addr_a) && !(ZERO_R0 && (rd_addr_a == '0));
        hit_b = wr_req.en && (wr_req.addr == rd_addr_b) && !(ZERO_R0 && (rd_addr_b == '0));
        rd_data_a = hit_a ? wr_req.data : mem[rd_addr_a];
        rd_data_b = hit_b ? wr_req.data : mem[rd_addr_b];
        pend_a = pend[rd_addr_a] && !(wr_req.en && (wr_req.addr == rd_addr_a));
        pend_b = pend[rd_addr_b] && !(wr_req.en && (wr_req.addr == rd_addr_b));
    end

    // ------------------------------------------------------------------
    // Dump engine
    // ------------------------------------------------------------------
    dump_state_t              state, state_nxt;
    logic [ADDR_W-1:0]        idx_nxt;
    logic [DATA_W-1:0]        data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dump_idx  <= '0;
            dump_data <= '0;
        end else begin
            state     <= state_nxt;
            dump_idx  <= idx_nxt;
            dump_data <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = dump_idx;
        data_nxt  = dump_data;
        case (state)
            IDLE: begin
                if (dump_start) begin
                    idx_nxt   = '0;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Snapshot from the array only; dump_data then stays frozen through SEND.
                data_nxt  = mem[dump_idx];
                state_nxt = SEND;
            end
            SEND: begin
                if (dump_ready) begin
                    if (dump_idx == LAST_IDX) begin
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt   = dump_idx + ADDR_W'(1);
                        state_nxt = FETCH;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dump_busy  = (state != IDLE);
    assign dump_valid = (state == SEND);

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a plain instance and a ZERO_R0 instance share all inputs;
// every check is an immediate assertion against hand-computed values.

module tb_regfile_param;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] rd_addr_a, rd_addr_b, wr_addr, pend_addr;
    logic [DATA_W-1:0] wr_data;
    logic              we, pend_set, dump_start, dump_ready;

    logic [DATA_W-1:0] rd_data_a, rd_data_b, dump_data;
    logic              pend_a, pend_b, dump_busy, dump_valid;
    logic [ADDR_W-1:0] dump_idx;

    logic [DATA_W-1:0] z_rd_data_a, z_rd_data_b, z_dump_data;
    logic              z_pend_a, z_pend_b, z_dump_busy, z_dump_valid;
    logic [ADDR_W-1:0] z_dump_idx;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b0)) u_dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_a(pend_a), .pend_b(pend_b),
        .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data)
    );

    regfile_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(1'b1)) u_dut_z (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_data_a(z_rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(z_rd_data_b),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_set(pend_set), .pend_addr(pend_addr),
        .pend_a(z_pend_a), .pend_b(z_pend_b),
        .dump_start(dump_start), .dump_busy(z_dump_busy), .dump_valid(z_dump_valid),
        .dump_ready(dump_ready), .dump_idx(z_dump_idx), .dump_data(z_dump_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!dump_valid && n < 8) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, dump_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; pend_set = 1'b0; dump_start = 1'b0; dump_ready = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; pend_addr = '0; wr_data = '0;
        tick(); tick();
        rst = 1'b0;
        #1;

        // 1: reset state
        for (int a = 0; a < 8; a++) begin
            rd_addr_a = ADDR_W'(a);
            rd_addr_b = ADDR_W'(7 - a);
            #1;
            chk($sformatf("rst_rd_a[%0d]", a), 32'(rd_data_a), 32'h0);
            chk($sformatf("rst_rd_b[%0d]", a), 32'(rd_data_b), 32'h0);
            chk($sformatf("rst_pend[%0d]", a), {30'd0, pend_a, pend_b}, 32'h0);
            chk($sformatf("rst_z_rd_a[%0d]", a), 32'(z_rd_data_a), 32'h0);
        end
        chk("rst_busy", {30'd0, dump_busy, dump_valid}, 32'h0);

        // 2: bypass on both ports, then stored value
        we = 1'b1; wr_addr = 3'd3; wr_data = 16'h1234; rd_addr_a = 3'd3; rd_addr_b = 3'd3;
        #1;
        chk("byp_a", 32'(rd_data_a), 32'h1234);
        chk("byp_b", 32'(rd_data_b), 32'h1234);
        tick();
        we = 1'b0;
        #1;
        chk("stored_a", 32'(rd_data_a), 32'h1234);
        chk("stored_b", 32'(rd_data_b), 32'h1234);

        // 3: R0 write -- zero instance ignores it, plain instance keeps it
        we = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF; rd_addr_a = 3'd0;
        #1;
        chk("z_r0_same", 32'(z_rd_data_a), 32'h0);
        chk("r0_byp", 32'(rd_data_a), 32'hFFFF);
        tick();
        we = 1'b0;
        #1;
        chk("z_r0_next", 32'(z_rd_data_a), 32'h0);
        chk("r0_next", 32'(rd_data_a), 32'hFFFF);
        pend_set = 1'b1; pend_addr = 3'd0;
        tick();
        pend_set = 1'b0;
        #1;
        chk("z_r0_pend", {31'd0, z_pend_a}, 32'h0);
        chk("r0_pend", {31'd0, pend_a}, 32'h1);
        we = 1'b1; wr_addr = 3'd0; wr_data = 16'h0000;
        #1;
        chk("r0_pend_clr_byp", {31'd0, pend_a}, 32'h0);
        tick();
        we = 1'b0;

        // 4: scoreboard set, bypassed clear, set-wins collision
        rd_addr_a = 3'd5; rd_addr_b = 3'd5;
        pend_set = 1'b1; pend_addr = 3'd5;
        #1;
        chk("pend5_before", {31'd0, pend_a}, 32'h0);
        tick();
        pend_set = 1'b0;
        #1;
        chk("pend5_set_a", {31'd0, pend_a}, 32'h1);
        chk("pend5_set_b", {31'd0, pend_b}, 32'h1);
        we = 1'b1; wr_addr = 3'd5; wr_data = 16'h0055;
        #1;
        chk("pend5_clr_byp", {31'd0, pend_a}, 32'h0);
        chk("data5_byp", 32'(rd_data_a), 32'h0055);
        tick();
        we = 1'b0;
        #1;
        chk("pend5_cleared", {31'd0, pend_a}, 32'h0);
        pend_set = 1'b1; pend_addr = 3'd5; we = 1'b1; wr_addr = 3'd5; wr_data = 16'h0056;
        tick();
        pend_set = 1'b0; we = 1'b0;
        #1;
        chk("pend5_set_wins", {31'd0, pend_a}, 32'h1);
        chk("data5_after", 32'(rd_data_a), 32'h0056);
        we = 1'b1; wr_addr = 3'd5;
        tick();
        we = 1'b0;

        // 5: full dump with consumer always ready
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i * 16'h0101);
            tick();
        end
        we = 1'b0;
        dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        #1;
        chk("fetch_busy", {30'd0, dump_busy, dump_valid}, 32'h2);
        for (int k = 0; k < 8; k++) begin
            wait_valid($sformatf("beat%0d_valid", k));
            chk($sformatf("beat%0d_idx", k), 32'(dump_idx), 32'(k));
            chk($sformatf("beat%0d_data", k), 32'(dump_data), 32'(k * 16'h0101));
            chk($sformatf("z_beat%0d_data", k), 32'(z_dump_data), 32'(k * 16'h0101));
            tick();
        end
        chk("dump_done_busy", {31'd0, dump_busy}, 32'h0);
        chk("dump_done_valid", {31'd0, dump_valid}, 32'h0);

        // 6: stall at idx2 while R2 is overwritten and start re-asserted, then reset mid-dump
        dump_start = 1'b1; dump_ready = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wait_valid($sformatf("d2_beat%0d_valid", k));
            tick();
        end
        wait_valid("d2_beat2_valid");
        chk("d2_idx2", 32'(dump_idx), 32'h2);
        dump_ready = 1'b0; dump_start = 1'b1;
        we = 1'b1; wr_addr = 3'd2; wr_data = 16'hBEEF;
        for (int c = 0; c < 5; c++) begin
            tick();
            we = 1'b0;
            #1;
            chk($sformatf("stall%0d_valid", c), {31'd0, dump_valid}, 32'h1);
            chk($sformatf("stall%0d_idx", c), 32'(dump_idx), 32'h2);
            chk($sformatf("stall%0d_data", c), 32'(dump_data), 32'h0202);
        end
        dump_start = 1'b0;
        rd_addr_a = 3'd2;
        #1;
        chk("r2_beef", 32'(rd_data_a), 32'hBEEF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dump_ready = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, dump_valid}, 32'h0);
        chk("rst_mid_busy", {31'd0, dump_busy}, 32'h0);
        chk("rst_mid_r2", 32'(rd_data_a), 32'h0);
        chk("rst_mid_idx", 32'(dump_idx), 32'h0);
        tick(); tick();
        chk("rst_mid_quiet", {30'd0, dump_busy, dump_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
